// File: rtl/sieve_reader_if.sv
// Signal bundle between the sieve reader, the sieve RAM read port and the display path.
// master is the reader side; slave is the RAM/key/display environment side.
interface sieve_reader_if #(
  parameter int AW = 20
);
  logic          start;
  logic          next_n;
  logic          r_data;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] count;
  logic          count_done;
  logic [AW-1:0] prime;
  logic [23:0]   digits;
  logic          valid;
  logic          busy;

  modport master (
    input  start, next_n, r_data,
    output r_addr, count, count_done, prime, digits, valid, busy
  );

  modport slave (
    output start, next_n, r_data,
    input  r_addr, count, count_done, prime, digits, valid, busy
  );
endinterface

// File: rtl/sieve_reader.sv
// Counts the primes in the sieve bitmap, then steps through them on key pulses
// and converts the selected prime to six BCD digits with a serial double dabble.
module sieve_reader #(
  parameter int N  = 1000000,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  sieve_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, COUNT, SEEK, CONV, SHOW} state_t;

  localparam int            CW    = $clog2(AW + 1);
  localparam logic [AW-1:0] FIRST = AW'(2);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [AW-1:0] ONE   = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] r_addr_q, r_addr_d;
  logic [AW-1:0] da_q, da_d;
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  logic [AW-1:0] count_q, count_d;
  logic          count_done_q, count_done_d;
  logic [AW-1:0] prime_q, prime_d;
  logic [AW-1:0] bin_q, bin_d;
  logic [23:0]   bcd_q, bcd_d;
  logic [23:0]   digits_q, digits_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [23:0]   bcd_adj;
  logic [23:0]   bcd_step;
  logic          hit;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST) ? FIRST : a + ONE;
  endfunction

  // vld_pipe[0]: r_addr carries a real read; vld_pipe[1]: r_data answers it.
  assign hit = vld_pipe_q[1] & bus.r_data;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[22:0], bin_q[AW-1]};
  end

  always_comb begin
    state_d      = state_q;
    r_addr_d     = r_addr_q;
    da_d         = r_addr_q;
    vld_pipe_d   = {vld_pipe_q[0], 1'b0};
    count_d      = count_q;
    count_done_d = count_done_q;
    prime_d      = prime_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    digits_d     = digits_q;
    valid_d      = valid_q;
    bit_d        = bit_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d       = COUNT;
          r_addr_d      = FIRST;
          vld_pipe_d[0] = 1'b1;
          count_d       = '0;
        end
      end
      COUNT: begin
        if (hit) count_d = count_q + ONE;
        if (vld_pipe_q[0]) begin
          if (r_addr_q != LAST) begin
            r_addr_d      = r_addr_q + ONE;
            vld_pipe_d[0] = 1'b1;
          end
        end else begin
          // drain cycle: the beat for N-1 has just been folded into count_d
          count_done_d = 1'b1;
          if (count_d == '0) begin
            state_d  = SHOW;
            prime_d  = '0;
            digits_d = '0;
            valid_d  = 1'b1;
          end else begin
            state_d       = SEEK;
            r_addr_d      = FIRST;
            vld_pipe_d[0] = 1'b1;
          end
        end
      end
      SEEK: begin
        if (hit) begin
          state_d = CONV;
          prime_d = da_q;
          bin_d   = da_q;
          bcd_d   = '0;
          bit_d   = '0;
        end else begin
          r_addr_d      = next_addr(r_addr_q);
          vld_pipe_d[0] = 1'b1;
        end
      end
      CONV: begin
        bcd_d = bcd_step;
        bin_d = bin_q << 1;
        bit_d = bit_q + CW'(1);
        if (bit_q == CW'(AW - 1)) begin
          state_d  = SHOW;
          digits_d = bcd_step;
          valid_d  = 1'b1;
        end
      end
      SHOW: begin
        if (!bus.next_n && count_q != '0) begin
          state_d       = SEEK;
          r_addr_d      = next_addr(prime_q);
          vld_pipe_d[0] = 1'b1;
          valid_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      r_addr_q     <= '0;
      da_q         <= '0;
      vld_pipe_q   <= '0;
      count_q      <= '0;
      count_done_q <= 1'b0;
      prime_q      <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      digits_q     <= '0;
      valid_q      <= 1'b0;
      bit_q        <= '0;
    end else begin
      state_q      <= state_d;
      r_addr_q     <= r_addr_d;
      da_q         <= da_d;
      vld_pipe_q   <= vld_pipe_d;
      count_q      <= count_d;
      count_done_q <= count_done_d;
      prime_q      <= prime_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      bit_q        <= bit_d;
    end
  end

  assign bus.r_addr     = r_addr_q;
  assign bus.count      = count_q;
  assign bus.count_done = count_done_q;
  assign bus.prime      = prime_q;
  assign bus.digits     = digits_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = (state_q == COUNT) || (state_q == SEEK) || (state_q == CONV);
endmodule
